adc_spi_responder: RTL and testbench

Synthesizable SPI slave that emulates the 12-bit two-channel ADC the scope front end reads. It decodes the start/config bits that an ADC master shifts out on MOSI and returns a selected 12-bit code on MISO. It sits on the slave end of the ADC bus, so `channel1`/`triggerLevel` ADC masters can be looped back on-board for self-test without the physical ADC. It also serves as a bus-functional responder in simulation. The whole block runs on the system clock and oversamples the SPI pins.

---
 rtl/adc_spi_responder.sv | 129 ++++++++++++
 tb/tb_adc_spi_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI slave that emulates a 12-bit two-channel ADC.
// Oversamples sclk/mosi/cs_n on clk and returns the selected code on miso.
module adc_spi_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    input  logic [11:0] code_ch0,
    input  logic [11:0] code_ch1,
    output logic        miso,
    output logic        ch_sel,
    output logic        sgl_diff,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        NUL,
        DATA
    } state_t;

    state_t      state;
    logic        sclk_s1;
    logic        sclk_s2;
    logic        sclk_s3;
    logic        mosi_s1;
    logic        mosi_s2;
    logic        cs_s1;
    logic        cs_s2;
    logic [11:0] shreg;
    logic [4:0]  cnt;
    logic        rise;
    logic        fall;

    // Two-flop synchronisers plus a third sclk stage for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
        end
    end

    assign rise = sclk_s2 & ~sclk_s3;
    assign fall = ~sclk_s2 & sclk_s3;

    // Frame state machine; rises sample mosi, falls update miso
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            miso       <= 1'b0;
            ch_sel     <= 1'b0;
            sgl_diff   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            shreg      <= '0;
            cnt        <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (cs_s2 && state != IDLE) begin
                // Chip select dropped mid-frame; it beats a same-cycle rise
                state     <= IDLE;
                miso      <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (fall) miso <= 1'b0;
                        if (rise && mosi_s2 && !cs_s2) begin
                            state <= CFG;
                            cnt   <= 5'd1;
                        end
                    end
                    CFG: begin
                        if (rise) begin
                            cnt <= cnt + 5'd1;
                            if (cnt == 5'd1) begin
                                sgl_diff <= mosi_s2;
                            end else if (cnt == 5'd2) begin
                                ch_sel <= mosi_s2;
                                shreg  <= mosi_s2 ? code_ch1 : code_ch0;
                            end else begin
                                state <= NUL;
                            end
                        end
                    end
                    NUL: begin
                        if (fall) miso <= 1'b0;
                        if (rise) begin
                            state <= DATA;
                            cnt   <= cnt + 5'd1;
                        end
                    end
                    DATA: begin
                        if (fall) begin
                            miso  <= shreg[11];
                            shreg <= {shreg[10:0], 1'b0};
                        end
                        if (rise) begin
                            cnt <= cnt + 5'd1;
                            if (cnt == 5'd16) begin
                                state      <= IDLE;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed bench for the ADC SPI responder.
// Master side bit-bangs sclk at clk/32 and checks returned codes.
module tb_adc_spi_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic [11:0] code_ch0 = 12'h123;
    logic [11:0] code_ch1 = 12'hA5C;
    logic        miso;
    logic        ch_sel;
    logic        sgl_diff;
    logic        frame_done;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    longint t_last = 0;
    longint t_prev = 0;

    logic [16:0] rx;
    int d0;
    int e0;

    localparam logic [16:0] F_CH1 = {4'b1111, 13'b0};
    localparam logic [16:0] F_CH0 = {4'b1101, 13'b0};

    always #5 clk = ~clk;

    adc_spi_responder dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .code_ch0   (code_ch0),
        .code_ch1   (code_ch1),
        .miso       (miso),
        .ch_sel     (ch_sel),
        .sgl_diff   (sgl_diff),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    // Count cycles each pulse is high and timestamp frame_done
    always @(posedge clk) begin
        if (frame_done === 1'b1) begin
            done_cnt++;
            t_prev = t_last;
            t_last = $time;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic zero_bit();
        mosi = 1'b0;
        repeat (16) @(negedge clk);
        sclk = 1'b1;
        repeat (16) @(negedge clk);
        sclk = 1'b0;
    endtask

    // kind: 0 none, 1 cs_n abort, 2 reset abort, 3 code change
    task automatic frame(input logic [16:0] bits, input int ev_at,
                         input int kind, output logic [16:0] rxo);
        int dd;
        int ee;
        rxo = '0;
        dd = done_cnt;
        ee = err_cnt;
        for (int i = 0; i < 17; i++) begin
            mosi = bits[16-i];
            repeat (16) @(negedge clk);
            rxo[16-i] = miso;
            sclk = 1'b1;
            if (i + 1 == ev_at && kind == 1) begin
                repeat (8) @(negedge clk);
                cs_n = 1'b1;
                repeat (8) @(negedge clk);
                sclk = 1'b0;
                repeat (16) @(negedge clk);
                chk("abort_miso", {31'b0, miso}, 32'd0);
                chk("abort_err_pulse", err_cnt - ee, 32'd1);
                chk("abort_no_done", done_cnt - dd, 32'd0);
                cs_n = 1'b0;
                return;
            end
            if (i + 1 == ev_at && kind == 2) begin
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                chk("rst_outs",
                    {27'b0, miso, ch_sel, sgl_diff, frame_done, frame_err},
                    32'd0);
                sclk = 1'b0;
                mosi = 1'b0;
                repeat (4) @(negedge clk);
                reset = 1'b1;
                repeat (8) @(negedge clk);
                chk("rst_no_err", err_cnt - ee, 32'd0);
                chk("rst_no_done", done_cnt - dd, 32'd0);
                return;
            end
            if (i + 1 == ev_at && kind == 3) begin
                repeat (5) @(negedge clk);
                code_ch1 = 12'hFFF;
                repeat (11) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("reset_state",
            {27'b0, miso, ch_sel, sgl_diff, frame_done, frame_err}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);

        // Basic read, channel 1
        d0 = done_cnt;
        frame(F_CH1, 0, 0, rx);
        chk("basic_rx", {15'b0, rx}, 32'h00A5C);
        chk("basic_ch_sel", {31'b0, ch_sel}, 32'd1);
        chk("basic_sgl", {31'b0, sgl_diff}, 32'd1);
        chk("basic_done", done_cnt - d0, 32'd1);
        chk("basic_idle_miso", {31'b0, miso}, 32'd0);

        // Channel 0 after leading zeros
        for (int k = 0; k < 3; k++) zero_bit();
        d0 = done_cnt;
        frame(F_CH0, 0, 0, rx);
        chk("ch0_rx", {15'b0, rx}, 32'h00123);
        chk("ch0_ch_sel", {31'b0, ch_sel}, 32'd0);
        chk("ch0_sgl", {31'b0, sgl_diff}, 32'd1);
        chk("ch0_done", done_cnt - d0, 32'd1);

        // Code change after rise 3 does not reach the frame
        frame(F_CH1, 3, 3, rx);
        chk("freeze_rx", {15'b0, rx}, 32'h00A5C);
        code_ch1 = 12'hA5C;

        // cs_n abort after rise 9, then a clean frame
        frame(F_CH1, 9, 1, rx);
        repeat (8) @(negedge clk);
        frame(F_CH0, 0, 0, rx);
        chk("post_abort_rx", {15'b0, rx}, 32'h00123);

        // Back-to-back frames, cs_n held low
        d0 = done_cnt;
        frame(F_CH1, 0, 0, rx);
        chk("b2b_rx1", {15'b0, rx}, 32'h00A5C);
        frame(F_CH0, 0, 0, rx);
        chk("b2b_rx2", {15'b0, rx}, 32'h00123);
        chk("b2b_done", done_cnt - d0, 32'd2);
        chk("b2b_spacing", 32'(t_last - t_prev), 32'd5440);

        // Reset in the data phase, then a full frame
        frame(F_CH1, 11, 2, rx);
        d0 = done_cnt;
        frame(F_CH1, 0, 0, rx);
        chk("post_rst_rx", {15'b0, rx}, 32'h00A5C);
        chk("post_rst_ch_sel", {31'b0, ch_sel}, 32'd1);
        chk("post_rst_done", done_cnt - d0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
